jk_step_source: RTL and testbench

JK_STEP_SOURCE -- requirements
Module: jk_step_source

---
 rtl/jk_step_pkg.sv | 32 +++
 rtl/debounce_sync.sv | 70 +++++++
 rtl/jk_step_source.sv | 57 +++++
 tb/tb_jk_step_source.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/jk_step_pkg.sv
// Shared types and defaults for the debounced JK step source.
// Holds the debouncer state enum, the JK update-table encoding and the default parameter values.
package jk_step_pkg;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
    localparam int unsigned DEF_SYNC_STAGES     = 2;

    typedef enum logic [1:0] {
        STABLE_LO,
        CHK_HI,
        STABLE_HI,
        CHK_LO
    } db_state_t;

    // Encoded as {J, K}
    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_CLR  = 2'b01,
        JK_SET  = 2'b10,
        JK_TOG  = 2'b11
    } jk_op_t;

    function automatic logic jk_next(input jk_op_t op, input logic q);
        case (op)
            JK_CLR:  return 1'b0;
            JK_SET:  return 1'b1;
            JK_TOG:  return ~q;
            default: return q;
        endcase
    endfunction

endpackage

// File: rtl/debounce_sync.sv
// Synchronizer chain followed by a four-state debouncer for one raw asynchronous input.
// clean changes only after the synchronized level has disagreed with it for DEBOUNCE_CYCLES cycles.
module debounce_sync
    import jk_step_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic clean
);

    localparam int unsigned   CW   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync;
    db_state_t              state, state_nxt;
    logic [CW-1:0]          count, count_nxt;

    always_ff @(posedge clk) begin
        if (rst) sync_ff <= '0;
        else     sync_ff <= {sync_ff[SYNC_STAGES-2:0], raw};
    end

    assign sync = sync_ff[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= STABLE_LO;
            count <= '0;
            clean <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            clean <= (state_nxt == STABLE_HI) || (state_nxt == CHK_LO);
        end
    end

    // Entering a CHK state already counts the first disagreeing cycle, so the
    // transition on count == LAST lands exactly DEBOUNCE_CYCLES cycles in.
    always_comb begin
        state_nxt = state;
        count_nxt = '0;
        case (state)
            STABLE_LO: if (sync) begin
                state_nxt = CHK_HI;
                count_nxt = CW'(1);
            end
            CHK_HI: begin
                if (!sync)              state_nxt = STABLE_LO;
                else if (count == LAST) state_nxt = STABLE_HI;
                else                    count_nxt = (count == '1) ? count : count + 1'b1;
            end
            STABLE_HI: if (!sync) begin
                state_nxt = CHK_LO;
                count_nxt = CW'(1);
            end
            CHK_LO: begin
                if (sync)               state_nxt = STABLE_HI;
                else if (count == LAST) state_nxt = STABLE_LO;
                else                    count_nxt = (count == '1) ? count : count + 1'b1;
            end
            default: state_nxt = STABLE_LO;
        endcase
    end

endmodule

// File: rtl/jk_step_source.sv
// JK flip-flop clocked by a debounced pushbutton, with debounced J/K switch inputs.
// Produces q/q_n for a downstream decoder plus a one-cycle strobe per accepted press.
module jk_step_source
    import jk_step_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic j_sw,
    input  logic k_sw,
    input  logic step_btn,
    output logic q,
    output logic q_n,
    output logic step_pulse,
    output logic j_clean,
    output logic k_clean
);

    logic step_clean;
    logic step_d;
    logic q_nxt;

    debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_j (
        .clk(clk), .rst(rst), .raw(j_sw), .clean(j_clean)
    );

    debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_k (
        .clk(clk), .rst(rst), .raw(k_sw), .clean(k_clean)
    );

    debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_step (
        .clk(clk), .rst(rst), .raw(step_btn), .clean(step_clean)
    );

    // Registered j_clean/k_clean are sampled here, so a same-cycle change is not seen.
    always_comb begin
        q_nxt = q;
        if (step_pulse) q_nxt = jk_next(jk_op_t'({j_clean, k_clean}), q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_d     <= 1'b0;
            step_pulse <= 1'b0;
            q          <= 1'b0;
            q_n        <= 1'b1;
        end else begin
            step_d     <= step_clean;
            step_pulse <= step_clean & ~step_d;
            q          <= q_nxt;
            q_n        <= ~q_nxt;
        end
    end

endmodule

// File: tb/tb_jk_step_source.sv
// Scoreboard bench for jk_step_source: a run-length reference model predicts every cycle's outputs,
// a monitor compares them at the falling edge, and directed scenarios check latencies and q sequences.
module tb_jk_step_source;

    localparam int unsigned DB = 4;
    localparam int unsigned SS = 2;

    logic clk = 1'b0;
    logic rst, j_sw, k_sw, step_btn;
    logic q, q_n, step_pulse, j_clean, k_clean;

    jk_step_source #(.DEBOUNCE_CYCLES(DB), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst(rst), .j_sw(j_sw), .k_sw(k_sw), .step_btn(step_btn),
        .q(q), .q_n(q_n), .step_pulse(step_pulse), .j_clean(j_clean), .k_clean(k_clean)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic pulse;
        logic q;
        logic j;
        logic k;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   pulse_tally = 0;
    logic cur_r = 1'b1, cur_j = 1'b0, cur_k = 1'b0, cur_b = 1'b0;

    // Reference model: sync delay line, run length of disagreement, clean level per input (0=J,1=K,2=step)
    logic        m_pipe [3][SS];
    int unsigned m_run  [3];
    logic        m_clean[3];
    logic        m_prev, m_pulse, m_q;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    endtask

    task automatic model_edge(input logic r, input logic rj, input logic rk, input logic rb);
        logic raw[3];
        logic s;
        raw[0] = rj; raw[1] = rk; raw[2] = rb;
        if (r) begin
            for (int unsigned i = 0; i < 3; i++) begin
                m_run[i] = 0;
                m_clean[i] = 1'b0;
                for (int unsigned k = 0; k < SS; k++) m_pipe[i][k] = 1'b0;
            end
            m_prev = 1'b0; m_pulse = 1'b0; m_q = 1'b0;
        end else begin
            if (m_pulse) begin
                if (m_clean[0] && m_clean[1])   m_q = ~m_q;
                else if (m_clean[0])            m_q = 1'b1;
                else if (m_clean[1])            m_q = 1'b0;
            end
            m_pulse = m_clean[2] & ~m_prev;
            m_prev  = m_clean[2];
            for (int unsigned i = 0; i < 3; i++) begin
                s = m_pipe[i][SS-1];
                if (s != m_clean[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_clean[i] = s;
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
                for (int unsigned k = SS - 1; k > 0; k--) m_pipe[i][k] = m_pipe[i][k-1];
                m_pipe[i][0] = raw[i];
            end
        end
    endtask

    task automatic step();
        rst = cur_r; j_sw = cur_j; k_sw = cur_k; step_btn = cur_b;
        @(posedge clk);
        model_edge(cur_r, cur_j, cur_k, cur_b);
        exp_q.push_back('{pulse: m_pulse, q: m_q, j: m_clean[0], k: m_clean[1]});
        cyc++;
        #1;
        if (step_pulse) pulse_tally++;
    endtask

    task automatic hold(input int n);
        repeat (n) step();
    endtask

    task automatic wait_pulse(output int n);
        n = 0;
        do begin step(); n++; end while (!step_pulse && n < 40);
    endtask

    task automatic wait_jclean(output int n);
        n = 0;
        do begin step(); n++; end while (!j_clean && n < 40);
    endtask

    task automatic press();
        cur_b = 1'b1; hold(9);
        cur_b = 1'b0; hold(9);
    endtask

    // Monitor: every cycle the DUT presents a full output set, compared against the queued prediction
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check($sformatf("outputs{pulse,q,qn,j,k}@cycle%0d", cyc),
                      int'({step_pulse, q, q_n, j_clean, k_clean}),
                      int'({e.pulse, e.q, ~e.q, e.j, e.k}));
            end
        end
    end

    initial begin
        int n, p0;

        // Reset then idle
        hold(3);
        cur_r = 1'b0;
        p0 = pulse_tally;
        hold(20);
        check("idle_no_pulse", pulse_tally - p0, 0);
        check("idle_q", int'(q), 0);
        check("idle_q_n", int'(q_n), 1);

        // J high, then a long press
        cur_j = 1'b1;
        wait_jclean(n);
        check("j_clean_latency", n, 6);
        hold(4);
        p0 = pulse_tally;
        cur_b = 1'b1; hold(10);
        check("hold_one_pulse", pulse_tally - p0, 1);
        check("hold_q_set", int'(q), 1);
        cur_b = 1'b0; hold(10);
        check("release_no_pulse", pulse_tally - p0, 1);

        // Bouncing press
        p0 = pulse_tally;
        cur_b = 1'b1; hold(2); cur_b = 1'b0; hold(2);
        cur_b = 1'b1; hold(2); cur_b = 1'b0; hold(2);
        check("bounce_no_pulse", pulse_tally - p0, 0);
        cur_b = 1'b1;
        wait_pulse(n);
        check("bounce_pulse_latency", n, 7);
        hold(4);
        check("bounce_single_pulse", pulse_tally - p0, 1);
        cur_b = 1'b0; hold(10);

        // Toggle sequence from a fresh reset
        cur_j = 1'b0; cur_r = 1'b1; hold(2);
        cur_r = 1'b0; cur_j = 1'b1; cur_k = 1'b1; hold(8);
        press(); check("toggle1_q", int'(q), 1); check("toggle1_q_n", int'(q_n), 0);
        press(); check("toggle2_q", int'(q), 0); check("toggle2_q_n", int'(q_n), 1);
        press(); check("toggle3_q", int'(q), 1); check("toggle3_q_n", int'(q_n), 0);

        // Clear, then hold
        cur_j = 1'b0; cur_k = 1'b1; hold(8);
        press(); check("clear_q", int'(q), 0);
        cur_k = 1'b0; hold(8);
        press(); check("hold_q", int'(q), 0);

        // Set q, then reset mid-debounce with the button held through release
        cur_j = 1'b1; hold(8);
        press(); check("preset_q", int'(q), 1);
        p0 = pulse_tally;
        cur_b = 1'b1; hold(4);
        cur_r = 1'b1; hold(2);
        check("reset_mid_no_pulse", pulse_tally - p0, 0);
        check("reset_mid_q", int'(q), 0);
        check("reset_mid_q_n", int'(q_n), 1);
        cur_r = 1'b0;
        wait_pulse(n);
        check("post_reset_pulse_latency", n, 7);
        cur_b = 1'b0; hold(10);

        // Randomized segments, checked only by the scoreboard
        for (int unsigned s = 0; s < 60; s++) begin
            cur_r = ($urandom_range(0, 19) == 0);
            cur_j = 1'($urandom_range(0, 1));
            cur_k = 1'($urandom_range(0, 1));
            cur_b = 1'($urandom_range(0, 1));
            hold(int'($urandom_range(1, 10)));
        end
        cur_r = 1'b0;
        hold(12);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
